// File: rtl/sy_pkg.sv
// Shared frontend types: quick-decode classes, address width and the RAS
// checkpoint bundle that fetch and backend carry as a single field.
package sy_pkg;

  localparam int AWTH      = 32;
  localparam int RAS_DEPTH = 8;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    QDEC_NORMAL    = 3'd0,
    QDEC_BRANCH    = 3'd1,
    QDEC_JUMP      = 3'd2,
    QDEC_JALR      = 3'd3,
    QDEC_CALL_JAL  = 3'd4,
    QDEC_CALL_JALR = 3'd5,
    QDEC_RET       = 3'd6
  } qdec_type_e;

  typedef struct packed {
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_CNT_W-1:0] cnt;
    logic [AWTH-1:0]      data;
  } ras_ckpt_t;

  // Link address of a call: next sequential instruction, modulo 2^AWTH.
  function automatic logic [AWTH-1:0] ras_ret_addr(input logic [AWTH-1:0] vaddr,
                                                   input logic            is_c);
    return vaddr + (is_c ? AWTH'(2) : AWTH'(4));
  endfunction

endpackage

// File: rtl/sy_ppl_ras.sv
// Return-address stack: circular register array with top-of-stack pointer and
// saturating occupancy count, repaired from a backend checkpoint on mispredict.
module sy_ppl_ras
  import sy_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dec_valid_i,
  input  qdec_type_e       dec_type_i,
  input  logic             dec_is_c_i,
  input  logic [AWTH-1:0]  dec_vaddr_i,
  output logic             ras_valid_o,
  output logic [AWTH-1:0]  ras_target_o,
  output logic [PTR_W-1:0] ckpt_ptr_o,
  output logic [CNT_W-1:0] ckpt_cnt_o,
  output logic [AWTH-1:0]  ckpt_data_o,
  input  logic             recover_i,
  input  logic [PTR_W-1:0] recover_ptr_i,
  input  logic [CNT_W-1:0] recover_cnt_i,
  input  logic [AWTH-1:0]  recover_data_i,
  input  logic             flush_i
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [AWTH-1:0]  stack_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [AWTH-1:0]  wr_data;

  logic             push, pop, empty;
  logic [AWTH-1:0]  ret_addr;

  assign push     = dec_valid_i & ((dec_type_i == QDEC_CALL_JAL) | (dec_type_i == QDEC_CALL_JALR));
  assign pop      = dec_valid_i & (dec_type_i == QDEC_RET);
  assign empty    = (cnt_q == '0);
  assign ret_addr = ras_ret_addr(dec_vaddr_i, dec_is_c_i);

  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = ret_addr;
    if (flush_i) begin
      tos_d = '0;
      cnt_d = '0;
    end else if (recover_i) begin
      tos_d   = recover_ptr_i;
      cnt_d   = (recover_cnt_i > CNT_FULL) ? CNT_FULL : recover_cnt_i;
      wr_en   = 1'b1;
      wr_idx  = recover_ptr_i;
      wr_data = recover_data_i;
    end else if (push && pop && !empty) begin
      // Return-then-call: the new link simply replaces the current top.
      wr_en = 1'b1;
    end else if (push) begin
      tos_d  = tos_q + PTR_W'(1);
      cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
      wr_en  = 1'b1;
      wr_idx = tos_q + PTR_W'(1);
    end else if (pop && !empty) begin
      tos_d = tos_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (wr_en) stack_q[wr_idx] <= wr_data;
    end
  end

  assign ras_target_o = stack_q[tos_q];
  assign ckpt_data_o  = stack_q[tos_q];
  assign ras_valid_o  = !empty;
  assign ckpt_ptr_o   = tos_q;
  assign ckpt_cnt_o   = cnt_q;

endmodule
